// File: rtl/farol_pkg.sv
`default_nettype none
// ============================================================================
// Module   : farol_pkg
// Purpose  : State codes and default timing constants for the headlight warning.
// Revision : 1.0
// ============================================================================
package farol_pkg;

  typedef enum logic [1:0] {
    INATIVO    = 2'b00,
    BIPANDO    = 2'b01,
    SILENCIADO = 2'b10,
    ESGOTADO   = 2'b11
  } estado_t;

  localparam int DEBOUNCE_PADRAO  = 8;
  localparam int BIP_ON_PADRAO    = 4;
  localparam int BIP_OFF_PADRAO   = 4;
  localparam int TEMPO_MAX_PADRAO = 64;

endpackage
`default_nettype wire

// File: rtl/filtro_entrada.sv
`default_nettype none
// ============================================================================
// Module   : filtro_entrada
// Purpose  : Two-flop synchroniser followed by a stability-counter debounce.
// Revision : 1.0
// ============================================================================
module filtro_entrada #(
  parameter int DEBOUNCE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic entrada_i,
  output logic saida_o
);

  localparam int CW = $clog2(DEBOUNCE) + 1;
  localparam logic [CW-1:0] c_cnt_fim = CW'(DEBOUNCE - 1);

  logic          sinc1_q, sinc2_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample matching the filtered value restarts the stability count.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sinc2_q != filt_q) begin
      if (cnt_q == c_cnt_fim) begin
        filt_d = sinc2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sinc1_q <= 1'b0;
      sinc2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sinc1_q <= entrada_i;
      sinc2_q <= sinc1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign saida_o = filt_q;

endmodule
`default_nettype wire

// File: rtl/controlador_sinalizador_farol.sv
`default_nettype none
// ============================================================================
// Module   : controlador_sinalizador_farol
// Purpose  : Headlight-left-on buzzer controller; AUTO_DESLIGA_EN adds the
//            headlight switch-off request on timeout.
// Revision : 1.0
// ============================================================================
module controlador_sinalizador_farol
  import farol_pkg::*;
#(
  parameter int DEBOUNCE  = DEBOUNCE_PADRAO,
  parameter int BIP_ON    = BIP_ON_PADRAO,
  parameter int BIP_OFF   = BIP_OFF_PADRAO,
  parameter int TEMPO_MAX = TEMPO_MAX_PADRAO
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       farol,
  input  logic       porta,
  input  logic       chave,
  input  logic       silenciar,
  output logic       saida,
  output logic       alerta,
  output logic       desliga_farol,
  output logic [1:0] estado
);

  localparam int FW = $clog2(BIP_ON + BIP_OFF) + 1;
  localparam int TW = $clog2(TEMPO_MAX) + 1;
  localparam logic [FW-1:0] c_fase_fim  = FW'(BIP_ON + BIP_OFF - 1);
  localparam logic [FW-1:0] c_bip_on    = FW'(BIP_ON);
  localparam logic [TW-1:0] c_total_fim = TW'(TEMPO_MAX - 1);

  // Bit order: [0] farol, [1] porta, [2] chave, [3] silenciar.
  logic [3:0]    w_bruto, w_filt;
  logic          w_cond, w_sil_borda;
  logic [FW-1:0] w_fase_prox;

  estado_t       estado_q;
  logic          saida_q, alerta_q, sil_ant_q;
  logic [FW-1:0] fase_q;
  logic [TW-1:0] total_q;

  assign w_bruto = {silenciar, chave, porta, farol};

  for (genvar gi = 0; gi < 4; gi++) begin : g_filtro
    filtro_entrada #(
      .DEBOUNCE (DEBOUNCE)
    ) u_filtro (
      .clk       (clk),
      .rst       (rst),
      .entrada_i (w_bruto[gi]),
      .saida_o   (w_filt[gi])
    );
  end

  assign w_cond      = w_filt[0] & ~(w_filt[1] & w_filt[2]);
  assign w_sil_borda = w_filt[3] & ~sil_ant_q;
  assign w_fase_prox = (fase_q == c_fase_fim) ? '0 : fase_q + 1'b1;

  // The FSM acts on the registered condition so beeping starts one cycle after alerta.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= INATIVO;
      saida_q   <= 1'b0;
      alerta_q  <= 1'b0;
      sil_ant_q <= 1'b0;
      fase_q    <= '0;
      total_q   <= '0;
    end else begin
      alerta_q  <= w_cond;
      sil_ant_q <= w_filt[3];
      case (estado_q)
        INATIVO: begin
          saida_q <= 1'b0;
          if (alerta_q) begin
            estado_q <= BIPANDO;
            saida_q  <= 1'b1;
            fase_q   <= '0;
            total_q  <= '0;
          end
        end
        BIPANDO: begin
          if (!alerta_q) begin
            estado_q <= INATIVO;
            saida_q  <= 1'b0;
          end else if (w_sil_borda) begin
            estado_q <= SILENCIADO;
            saida_q  <= 1'b0;
          end else if (total_q == c_total_fim) begin
            estado_q <= ESGOTADO;
            saida_q  <= 1'b0;
          end else begin
            total_q <= total_q + 1'b1;
            fase_q  <= w_fase_prox;
            saida_q <= (w_fase_prox < c_bip_on);
          end
        end
        SILENCIADO, ESGOTADO: begin
          saida_q <= 1'b0;
          if (!alerta_q) begin
            estado_q <= INATIVO;
          end
        end
        default: begin
          estado_q <= INATIVO;
          saida_q  <= 1'b0;
        end
      endcase
    end
  end

  assign saida  = saida_q;
  assign alerta = alerta_q;
  assign estado = estado_q;

`ifdef AUTO_DESLIGA_EN
  logic desliga_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      desliga_q <= 1'b0;
    end else if (!w_filt[0]) begin
      desliga_q <= 1'b0;
    end else if (estado_q == BIPANDO && alerta_q && !w_sil_borda &&
                 total_q == c_total_fim) begin
      desliga_q <= 1'b1;
    end
  end

  assign desliga_farol = desliga_q;
`else
  assign desliga_farol = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_controlador_sinalizador_farol.sv
`default_nettype none
// Scoreboard bench: a history-based reference model predicts each cycle's outputs.
module tb_controlador_sinalizador_farol;

  localparam int DEB  = 4;
  localparam int ON   = 3;
  localparam int OFF  = 2;
  localparam int TMAX = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       farol = 1'b0, porta = 1'b0, chave = 1'b0, silenciar = 1'b0;
  logic       saida, alerta, desliga_farol;
  logic [1:0] estado;

  controlador_sinalizador_farol #(
    .DEBOUNCE  (DEB),
    .BIP_ON    (ON),
    .BIP_OFF   (OFF),
    .TEMPO_MAX (TMAX)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .farol         (farol),
    .porta         (porta),
    .chave         (chave),
    .silenciar     (silenciar),
    .saida         (saida),
    .alerta        (alerta),
    .desliga_farol (desliga_farol),
    .estado        (estado)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       saida;
    logic       alerta;
    logic       desl;
    logic [1:0] estado;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   tests = 0;
  int   fails = 0;
  bit   done = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model: raw history since reset ([0] farol .. [3] silenciar).
  logic [3:0] m_raw[$];
  logic [3:0] m_f = '0;
  logic       m_sil_old = 1'b0, m_alerta = 1'b0, m_desl = 1'b0;
  int         m_mode = 0, m_k = 0;

  task automatic model_edge(input logic r, input logic [3:0] raw, input int cyc);
    exp_t       e;
    logic [3:0] f_prev;
    logic       rise, entrou, todos;
    int         used;
    entrou = 1'b0;
    if (r) begin
      m_raw.delete();
      m_raw.push_back(4'b0000);
      m_raw.push_back(4'b0000);
      m_f = '0; m_sil_old = 1'b0; m_alerta = 1'b0; m_desl = 1'b0;
      m_mode = 0; m_k = 0;
    end else begin
      f_prev = m_f;
      rise   = f_prev[3] & ~m_sil_old;
      case (m_mode)
        0: if (m_alerta) begin m_mode = 1; m_k = 0; end
        1: begin
          if (!m_alerta) m_mode = 0;
          else if (rise) m_mode = 2;
          else if (m_k == TMAX - 1) begin m_mode = 3; entrou = 1'b1; end
          else m_k++;
        end
        default: if (!m_alerta) m_mode = 0;
      endcase
`ifdef AUTO_DESLIGA_EN
      if (!f_prev[0]) m_desl = 1'b0;
      else if (entrou) m_desl = 1'b1;
`endif
      m_alerta  = f_prev[0] & ~(f_prev[1] & f_prev[2]);
      m_sil_old = f_prev[3];
      m_raw.push_back(raw);
      used = m_raw.size() - 2;
      for (int i = 0; i < 4; i++) begin
        if (used >= DEB) begin
          todos = 1'b1;
          for (int j = 0; j < DEB; j++)
            if (m_raw[used-1-j][i] == m_f[i]) todos = 1'b0;
          if (todos) m_f[i] = ~m_f[i];
        end
      end
      while (m_raw.size() > 64) void'(m_raw.pop_front());
    end
    e.cyc    = cyc;
    e.saida  = (m_mode == 1) && ((m_k % (ON + OFF)) < ON);
    e.alerta = m_alerta;
    e.desl   = m_desl;
    e.estado = 2'(m_mode);
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic [3:0] v);
    @(posedge clk);
    #1;
    rst = r;
    {silenciar, chave, porta, farol} = v;
    model_edge(r, v, edge_cnt + 1);
  endtask

  task automatic hold(input logic r, input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) step(r, v);
  endtask

  task automatic chk(input string nome, input int cyc, input logic [1:0] got, input logic [1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nome, cyc, got, exp);
    end
  endtask

  // Monitor: compares the DUT against the entry queued for this edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      while (sb.size() > 0 && sb[0].cyc < edge_cnt) begin
        e = sb.pop_front();
        tests++; fails++;
        $display("FAIL scoreboard_stale cycle=%0d got=none expected=%0d", edge_cnt, e.cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == edge_cnt) begin
        e = sb.pop_front();
        chk("saida",         edge_cnt, {1'b0, saida},         {1'b0, e.saida});
        chk("alerta",        edge_cnt, {1'b0, alerta},        {1'b0, e.alerta});
        chk("desliga_farol", edge_cnt, {1'b0, desliga_farol}, {1'b0, e.desl});
        chk("estado",        edge_cnt, estado,                e.estado);
      end
    end
  end

  initial begin
    #2000000;
    if (!done) begin
      $display("FAIL watchdog time limit reached got=running expected=finished");
      $fatal(1, "watchdog");
    end
  end

  initial begin
    logic [3:0] cur, g;
    int         sel;
    // v = {silenciar, chave, porta, farol}
    hold(1'b1, 4'b0000, 3);
    hold(1'b0, 4'b0111, 30);
    hold(1'b0, 4'b0101, 60);
    hold(1'b0, 4'b0111, 15);
    hold(1'b0, 4'b0110, 15);
    hold(1'b0, 4'b0101, 14);
    hold(1'b0, 4'b1101, 10);
    hold(1'b0, 4'b0101, 8);
    hold(1'b0, 4'b1101, 8);
    hold(1'b0, 4'b0111, 20);
    hold(1'b0, 4'b0101, 3);
    hold(1'b0, 4'b0111, 15);
    hold(1'b0, 4'b0101, 14);
    hold(1'b0, 4'b0111, 1);
    hold(1'b0, 4'b1111, 20);
    hold(1'b0, 4'b0111, 10);
    hold(1'b0, 4'b0101, 14);
    hold(1'b1, 4'b0101, 1);
    hold(1'b0, 4'b0101, 30);
    hold(1'b0, 4'b0100, 15);
    cur = 4'b0111;
    for (int s = 0; s < 220; s++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        hold(1'b1, cur, int'($urandom_range(1, 2)));
      end else if (sel <= 2) begin
        g = cur ^ 4'(1 << $urandom_range(0, 3));
        hold(1'b0, g, int'($urandom_range(1, DEB + 1)));
        hold(1'b0, cur, int'($urandom_range(2, 8)));
      end else begin
        cur = {($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) != 0)};
        hold(1'b0, cur, int'($urandom_range(3, 45)));
      end
    end
    repeat (3) @(posedge clk);
    #5;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
